// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue; the extra pointer bit separates full from empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [PTR_W-1:0] count
);

    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        count = wr_q - rd_q;
        empty = (count == '0);
        rdata = mem_q[rd_q[PTR_W-2:0]];
    end

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q[PTR_W-2:0]] = wdata;
                wr_d = wr_q + PTR_W'(1);
            end
            if (pop && !empty) begin
                rd_d = rd_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch FSM with one outstanding request, credit-based flow
// control into the instruction queue, branch hold and redirect/squash.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BRANCH_HOLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            hold
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             push, pop, flush;
    logic             still_outstanding;
    logic [2*XLEN-1:0] fifo_rdata;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({mem_rdata, req_pc_q}),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            REQ: begin
                if (mem_req && mem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (mem_valid) begin
                    push    = 1'b1;
                    state_d = ((BRANCH_HOLD != 0) && (mem_rdata[6:0] == OP_BRANCH)) ? HOLD : REQ;
                end
            end
            HOLD: ;
            DROP: begin
                if (mem_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
        // A response arriving in the redirect cycle closes the old request,
        // so only a still-pending or freshly granted one needs draining.
        still_outstanding = (state_q == REQ && mem_req && mem_gnt) ||
                            ((state_q == WAIT || state_q == DROP) && !mem_valid);
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~XLEN'(3);
            flush   = 1'b1;
            push    = 1'b0;
            state_d = still_outstanding ? DROP : REQ;
        end
    end

    always_comb begin
        mem_req     = rst_n && (state_q == REQ) && (fifo_count < CNT_W'(DEPTH));
        mem_addr    = pc_q;
        hold        = (state_q == HOLD);
        instr_valid = !fifo_empty;
        instr       = fifo_empty ? XLEN'(NOP) : fifo_rdata[2*XLEN-1:XLEN];
        instr_pc    = fifo_empty ? '0 : fifo_rdata[XLEN-1:0];
        pop         = instr_valid && instr_ready && !redirect_valid;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hold;

    instr_fetch_unit #(
        .XLEN        (32),
        .DEPTH       (DEPTH),
        .RESET_PC    (RST_PC),
        .BRANCH_HOLD (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_valid      (mem_valid),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hold           (hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    typedef struct {
        logic        gnt;
        logic        vld;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_hold;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: fetch pointer, buffered entries and one pending request.
    logic [31:0] m_pc;
    entry_t      m_q[$];
    logic        m_out;
    logic [31:0] m_out_pc;
    logic        m_drop;
    logic        m_hold;
    int          m_wait;
    int          lat_min = 0;
    int          lat_max = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a[6:2] == 5'd7) return {a[24:0], 7'b1100011};
        return {a[24:0], 7'b0010011};
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic exp_req;
        exp_req = !m_hold && !m_out && (m_q.size() < DEPTH);
        checkValue("mem_req", mem_req, exp_req);
        checkValue("mem_addr", mem_addr, m_pc);
        checkValue("instr_valid", instr_valid, m_q.size() > 0);
        checkValue("instr", instr, (m_q.size() > 0) ? m_q[0].instr : 32'h13);
        checkValue("instr_pc", instr_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
        checkValue("hold", hold, m_hold);
    endtask

    task automatic applyStimulus(input logic gnt, input logic rdy, input logic redir, input logic [31:0] rpc);
        logic        exp_req, vld, pop, granted, pending;
        logic [31:0] rdata;
        exp_req = !m_hold && !m_out && (m_q.size() < DEPTH);
        vld     = m_out && (m_wait == 0);
        rdata   = vld ? memWord(m_out_pc) : $urandom();
        mem_gnt = gnt; mem_valid = vld; mem_rdata = rdata;
        instr_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
        @(posedge clk);
        if (m_out && !vld) m_wait--;
        pop     = (m_q.size() > 0) && rdy;
        granted = exp_req && gnt;
        if (redir) begin
            pending = granted || (m_out && !vld);
            m_q.delete();
            m_hold = 1'b0;
            m_pc   = rpc & 32'hFFFF_FFFC;
            if (granted) m_wait = $urandom_range(lat_min, lat_max);
            m_out  = pending;
            m_drop = pending;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (vld) begin
                m_out = 1'b0;
                if (!m_drop) begin
                    m_q.push_back({rdata, m_out_pc});
                    if (rdata[6:0] == 7'b1100011) m_hold = 1'b1;
                end
                m_drop = 1'b0;
            end else if (granted) begin
                m_out    = 1'b1;
                m_out_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_drop   = 1'b0;
                m_wait   = $urandom_range(lat_min, lat_max);
            end
        end
        #1;
        checkOutput();
    endtask

    task automatic checkResetValues(input string tag);
        checkValue({tag, "_mem_req"}, mem_req, 1'b0);
        checkValue({tag, "_mem_addr"}, mem_addr, RST_PC);
        checkValue({tag, "_instr_valid"}, instr_valid, 1'b0);
        checkValue({tag, "_instr"}, instr, 32'h13);
        checkValue({tag, "_instr_pc"}, instr_pc, 32'h0);
        checkValue({tag, "_hold"}, hold, 1'b0);
    endtask

    initial begin
        vec_t vecs[15];
        vecs[0]  = '{1, 0, 32'h0,        0, 0, 32'h0,   0, 32'hFFFFFFFC, 0, 32'h13,       32'h0,        0};
        vecs[1]  = '{0, 1, 32'h00100093, 0, 0, 32'h0,   1, 32'hFFFFFFFC, 1, 32'h00100093, 32'hFFFFFFF8, 0};
        vecs[2]  = '{1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h00000000, 1, 32'h00100093, 32'hFFFFFFF8, 0};
        vecs[3]  = '{0, 1, 32'h00200113, 1, 0, 32'h0,   1, 32'h00000000, 1, 32'h00200113, 32'hFFFFFFFC, 0};
        vecs[4]  = '{1, 0, 32'h0,        1, 0, 32'h0,   0, 32'h00000004, 0, 32'h13,       32'h0,        0};
        vecs[5]  = '{0, 1, 32'h00000063, 0, 0, 32'h0,   0, 32'h00000004, 1, 32'h00000063, 32'h0,        1};
        vecs[6]  = '{1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h00000004, 1, 32'h00000063, 32'h0,        1};
        vecs[7]  = '{0, 0, 32'h0,        1, 1, 32'h42,  1, 32'h00000040, 0, 32'h13,       32'h0,        0};
        vecs[8]  = '{1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h00000044, 0, 32'h13,       32'h0,        0};
        vecs[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h00000044, 0, 32'h13,       32'h0,        0};
        vecs[10] = '{0, 1, 32'h00300193, 1, 0, 32'h0,   1, 32'h00000044, 1, 32'h00300193, 32'h40,       0};
        vecs[11] = '{1, 0, 32'h0,        1, 1, 32'h100, 0, 32'h00000100, 0, 32'h13,       32'h0,        0};
        vecs[12] = '{0, 1, 32'h00400213, 0, 0, 32'h0,   1, 32'h00000100, 0, 32'h13,       32'h0,        0};
        vecs[13] = '{1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h00000104, 0, 32'h13,       32'h0,        0};
        vecs[14] = '{0, 1, 32'h00500293, 0, 0, 32'h0,   1, 32'h00000104, 1, 32'h00500293, 32'h100,      0};

        rst_n = 1'b0; mem_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        #1;
        checkValue("first_req", mem_req, 1'b1);
        checkValue("first_addr", mem_addr, RST_PC);

        for (int i = 0; i < 15; i++) begin
            mem_gnt = vecs[i].gnt; mem_valid = vecs[i].vld; mem_rdata = vecs[i].rdata;
            instr_ready = vecs[i].rdy; redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            checkValue($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].e_req);
            checkValue($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            checkValue($sformatf("vec%0d_instr_valid", i), instr_valid, vecs[i].e_iv);
            checkValue($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
            checkValue($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].e_ipc);
            checkValue($sformatf("vec%0d_hold", i), hold, vecs[i].e_hold);
        end

        m_q.delete();
        m_q.push_back({32'h00500293, 32'h100});
        m_pc = 32'h104; m_out = 1'b0; m_drop = 1'b0; m_hold = 1'b0; m_wait = 0; m_out_pc = '0;

        // Fill with the decoder stalled, then drain and watch fetch resume.
        lat_min = 0; lat_max = 0;
        applyStimulus(0, 0, 1, 32'h0);
        repeat (12) applyStimulus(1, 0, 0, 32'h0);
        checkValue("fill_instr_valid", instr_valid, 1'b1);
        checkValue("fill_head_pc", instr_pc, 32'h0);
        checkValue("fill_mem_req", mem_req, 1'b0);
        checkValue("fill_mem_addr", mem_addr, 32'h10);
        for (int i = 0; i < 4; i++) begin
            checkValue("drain_pc", instr_pc, 32'(i * 4));
            applyStimulus(1, 1, 0, 32'h0);
            if (i == 0) begin
                checkValue("resume_req", mem_req, 1'b1);
                checkValue("resume_addr", mem_addr, 32'h10);
            end
        end
        repeat (20) applyStimulus(1, 1, 0, 32'h0);
        checkValue("branch_hold", hold, 1'b1);
        checkValue("branch_no_req", mem_req, 1'b0);
        applyStimulus(0, 1, 1, 32'h40);
        checkValue("redirect_req", mem_req, 1'b1);
        checkValue("redirect_addr", mem_addr, 32'h40);
        checkValue("redirect_hold", hold, 1'b0);

        // Redirect while a slow response is pending; it must be discarded.
        lat_min = 3; lat_max = 3;
        applyStimulus(0, 0, 1, 32'h0C);
        applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(0, 0, 1, 32'h100);
        checkValue("drop_empty", instr_valid, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, 32'h0);
            if (instr_valid) break;
        end
        checkValue("drop_first_iv", instr_valid, 1'b1);
        checkValue("drop_first_pc", instr_pc, 32'h100);

        // Reset in the middle of a wait, followed by the orphaned response.
        applyStimulus(0, 0, 1, 32'h20);
        applyStimulus(1, 0, 0, 32'h0);
        mem_gnt = 1'b0; mem_valid = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkResetValues("midwait_reset");
        rst_n = 1'b1;
        mem_valid = 1'b1; mem_rdata = 32'h00700393;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        checkValue("stray_instr_valid", instr_valid, 1'b0);
        checkValue("stray_mem_req", mem_req, 1'b1);
        checkValue("stray_mem_addr", mem_addr, RST_PC);
        m_q.delete();
        m_pc = RST_PC; m_out = 1'b0; m_drop = 1'b0; m_hold = 1'b0; m_wait = 0;

        lat_min = 0; lat_max = 2;
        for (int i = 0; i < 3000; i++) begin
            logic        g, r, rd;
            logic [31:0] rp;
            g  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 19) == 0);
            rp = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h3FF);
            applyStimulus(g, r, rd, rp);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
